// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: in-order command buffer in front of the ALU.
// Holds up to DEPTH {a, b, op} commands. The oldest command is shown
// first-word-fall-through on a/b/op_code. Also keeps occupancy and issue counts.
module alu_cmd_fifo #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 2,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [OP_W-1:0]   op_code,
    output logic [CW-1:0]     count,
    output logic [15:0]       issue_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   issue_cnt_q, issue_cnt_d;

    logic push;
    logic pop;
    cmd_t head;

    // in_ready and out_valid come only from the registered count. This keeps
    // out_ready off the input side, so a full FIFO refuses a push even while it pops.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head      = mem_q[rd_ptr_q];
    assign a         = out_valid ? head.a  : '0;
    assign b         = out_valid ? head.b  : '0;
    assign op_code   = out_valid ? head.op : '0;
    assign count     = count_q;
    assign issue_cnt = issue_cnt_q;

    // Next-state for the pointers, occupancy, issue counter and storage.
    // Flush wins over push and pop, and it leaves issue_cnt as it is.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        issue_cnt_d = issue_cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{a: in_a, b: in_b, op: in_op};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + PW'(1);
                issue_cnt_d = issue_cnt_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            issue_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    // Command storage is data only and has no reset. The head outputs are masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_alu_cmd_fifo.sv
// Directed testbench for alu_cmd_fifo (DATA_W=8, OP_W=2, DEPTH=4).
module tb_alu_cmd_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op_code;
    logic [2:0] count;
    logic [15:0] issue_cnt;

    int errors = 0;
    int checks = 0;

    alu_cmd_fifo #(.DATA_W(8), .OP_W(2), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .op_code   (op_code),
        .count     (count),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0;
        #2;
        // Reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_a", 32'(a), 0);
        chk("rst_issue", 32'(issue_cnt), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single command
        in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h01; in_op = 2'b00;
        tick();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 1);
        chk("single_a", 32'(a), 32'h0F);
        chk("single_b", 32'(b), 32'h01);
        chk("single_op", 32'(op_code), 0);
        chk("single_count", 32'(count), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_pop_count", 32'(count), 0);
        chk("single_pop_valid", 32'(out_valid), 0);
        chk("single_pop_a", 32'(a), 0);
        chk("single_pop_issue", 32'(issue_cnt), 1);

        // Fill to full, refuse a fifth command, drain in order
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_a = 8'(i); in_b = 8'(i + 16); in_op = 2'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("full_count", 32'(count), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1; in_a = 8'd5;
        tick();
        in_valid = 1'b0;
        chk("full_refuse_count", 32'(count), 4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_a", 32'(a), 32'(i));
            chk("drain_op", 32'(op_code), 32'(i % 4));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_count", 32'(count), 0);
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_issue", 32'(issue_cnt), 5);

        // Full with push and pop in the same cycle: pop only
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 8'(8'h21 + i); in_b = 8'h00; in_op = 2'b01;
            tick();
        end
        in_valid = 1'b1; in_a = 8'h25; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("fullrw_count", 32'(count), 3);
        chk("fullrw_in_ready", 32'(in_ready), 1);
        chk("fullrw_head", 32'(a), 32'h22);
        chk("fullrw_issue", 32'(issue_cnt), 6);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("fullrw_drain_a", 32'(a), 32'(8'h22 + i));
            tick();
        end
        out_ready = 1'b0;
        chk("fullrw_empty", 32'(count), 0);
        chk("fullrw_issue2", 32'(issue_cnt), 9);

        // Streaming with out_ready held high, the pointers wrap
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_a = 8'(10 + k); in_b = 8'(k); in_op = 2'(k);
            tick();
            chk("stream_a", 32'(a), 32'(10 + k));
            chk("stream_b", 32'(b), 32'(k));
            chk("stream_count", 32'(count), 1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("stream_end_count", 32'(count), 0);
        chk("stream_issue", 32'(issue_cnt), 19);

        // Flush with a push and pop in the same cycle
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 8'(8'h31 + i); in_b = 8'h00; in_op = 2'b00;
            tick();
        end
        in_valid = 1'b0;
        chk("preflush_count", 32'(count), 3);
        flush = 1'b1; in_valid = 1'b1; in_a = 8'h34; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_issue", 32'(issue_cnt), 19);
        chk("flush_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1; in_a = 8'h35; in_b = 8'hAA; in_op = 2'b11;
        tick();
        in_valid = 1'b0;
        chk("postflush_a", 32'(a), 32'h35);
        chk("postflush_b", 32'(b), 32'hAA);
        chk("postflush_op", 32'(op_code), 3);
        chk("postflush_count", 32'(count), 1);

        // Asynchronous reset between clock edges
        in_valid = 1'b1; in_a = 8'h36; in_b = 8'h01; in_op = 2'b10;
        tick();
        in_valid = 1'b0;
        chk("prerst_count", 32'(count), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_a", 32'(a), 0);
        chk("arst_b", 32'(b), 0);
        chk("arst_op", 32'(op_code), 0);
        chk("arst_issue", 32'(issue_cnt), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("after_rst_count", 32'(count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
